// File: rtl/t03_countdown_timer.sv
// Two-digit BCD countdown timer with tick prescaler.
// Ticks come from an upstream divider; clear > start > pause > tick.
module t03_countdown_timer #(
  parameter int unsigned TICKS_PER_STEP = 1
) (
  input  logic       hwclk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic [7:0] load_val,
  output logic [7:0] count_bcd,
  output logic       running,
  output logic       done,
  output logic       expired
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE
  } state_t;

  localparam logic [7:0] PRE_MAX = 8'(TICKS_PER_STEP - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] pre_q, pre_d;
  logic       exp_q, exp_d;
  logic [7:0] ld;

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0)
      return {v[7:4] - 4'd1, 4'd9};
    else
      return {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign ld = {clamp9(load_val[7:4]), clamp9(load_val[3:0])};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    exp_d   = 1'b0;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = 8'h00;
      pre_d   = 8'd0;
    end else if (start) begin
      cnt_d = ld;
      pre_d = 8'd0;
      if (ld == 8'h00) begin
        state_d = DONE;
        exp_d   = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (tick) begin
            if (pre_q < PRE_MAX) begin
              pre_d = pre_q + 8'd1;
            end else begin
              pre_d = 8'd0;
              cnt_d = bcd_dec(cnt_q);
              // Last step lands in DONE on the same edge
              if (cnt_q == 8'h01) begin
                state_d = DONE;
                exp_d   = 1'b1;
              end
            end
          end
        end
        PAUSED: begin
          if (!pause) state_d = RUN;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'h00;
      pre_q   <= 8'd0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      exp_q   <= exp_d;
    end
  end

  assign count_bcd = cnt_q;
  assign running   = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign expired   = exp_q;

endmodule
